box_motion_controller: RTL and testbench

//  Sequences the player box's vertical motion for the flappy-box game.

---
 rtl/box_motion_controller.sv | 176 +++++++++++++++++
 tb/tb_box_motion_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/box_motion_controller.sv
// Vertical motion sequencer for the flappy-box player: tick divider, flap/gravity
// integration and READY/FLYING/FALLING/CRASHED control with floor and ceiling limits.
module box_motion_controller #(
    parameter int TICK_DIV     = 833333,
    parameter int Y_START      = 60,
    parameter int Y_FLOOR      = 112,
    parameter int FLAP_VEL     = 6,
    parameter int MAX_FALL_VEL = 7,
    parameter int GRAV_TICKS   = 4
) (
    input  logic       game_tick_clock,
    input  logic       resetn,
    input  logic       tap,
    input  logic       start,
    output logic [6:0] y_coordinate,
    output logic [3:0] velocity,
    output logic       moving_up,
    output logic [1:0] state,
    output logic       update_tick,
    output logic       crashed
);

    localparam int DIV_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int GRAV_W = $clog2(GRAV_TICKS + 1);

    typedef enum logic [1:0] {
        ST_READY   = 2'd0,
        ST_FALLING = 2'd1,
        ST_FLYING  = 2'd2,
        ST_CRASHED = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [GRAV_W-1:0] grav_q, grav_d;
    logic [6:0]        y_q, y_d;
    logic [3:0]        vel_q, vel_d;
    logic              tap_pending_q, tap_pending_d;
    logic              update_tick_q, update_tick_d;
    logic              moving_up_q, moving_up_d;
    logic              crashed_q, crashed_d;

    logic              tick;
    logic              in_air;
    logic              flap;
    logic signed [7:0] y_up;
    logic [7:0]        y_dn;
    logic [GRAV_W-1:0] grav_inc;
    logic              grav_wrap;

    // Falling speed grows by one per gravity step but never past terminal velocity.
    function automatic logic [3:0] sat_fall_inc(input logic [3:0] v);
        if (v >= 4'(MAX_FALL_VEL))
            return 4'(MAX_FALL_VEL);
        return v + 4'd1;
    endfunction

    // Rising speed decays towards zero without wrapping.
    function automatic logic [3:0] sat_rise_dec(input logic [3:0] v);
        if (v == 4'd0)
            return 4'd0;
        return v - 4'd1;
    endfunction

    always_comb begin
        tick      = (div_q == DIV_W'(TICK_DIV - 1));
        div_d     = tick ? '0 : div_q + 1'b1;
        in_air    = (state_q == ST_FALLING) || (state_q == ST_FLYING);
        flap      = in_air && (tap_pending_q || tap);
        y_up      = $signed({1'b0, y_q}) - $signed({4'b0, vel_q});
        y_dn      = {1'b0, y_q} + {4'b0, vel_q};
        grav_inc  = grav_q + 1'b1;
        grav_wrap = (grav_inc == GRAV_W'(GRAV_TICKS));

        tap_pending_d = tick ? 1'b0 : (tap_pending_q || (in_air && tap));
        state_d       = state_q;
        y_d           = y_q;
        vel_d         = vel_q;
        grav_d        = grav_q;

        case (state_q)
            ST_READY: begin
                y_d   = 7'(Y_START);
                vel_d = 4'd0;
                if (start) begin
                    state_d = ST_FLYING;
                    vel_d   = 4'(FLAP_VEL);
                    grav_d  = '0;
                end
            end
            ST_CRASHED: begin
                if (start) begin
                    state_d = ST_READY;
                    y_d     = 7'(Y_START);
                    vel_d   = 4'd0;
                    grav_d  = '0;
                end
            end
            ST_FLYING: begin
                if (tick) begin
                    if (flap) begin
                        vel_d  = 4'(FLAP_VEL);
                        grav_d = '0;
                    end else if (y_up <= 8'sd0) begin
                        // Hitting the ceiling stops the climb but is not a crash.
                        y_d     = 7'd0;
                        vel_d   = 4'd0;
                        state_d = ST_FALLING;
                    end else begin
                        y_d    = y_up[6:0];
                        grav_d = grav_wrap ? '0 : grav_inc;
                        if (grav_wrap) begin
                            vel_d = sat_rise_dec(vel_q);
                            if (sat_rise_dec(vel_q) == 4'd0)
                                state_d = ST_FALLING;
                        end
                    end
                end
            end
            default: begin
                if (tick) begin
                    if (flap) begin
                        vel_d   = 4'(FLAP_VEL);
                        grav_d  = '0;
                        state_d = ST_FLYING;
                    end else if (y_dn >= 8'(Y_FLOOR)) begin
                        y_d     = 7'(Y_FLOOR);
                        vel_d   = 4'd0;
                        state_d = ST_CRASHED;
                    end else begin
                        y_d    = y_dn[6:0];
                        grav_d = grav_wrap ? '0 : grav_inc;
                        if (grav_wrap)
                            vel_d = sat_fall_inc(vel_q);
                    end
                end
            end
        endcase

        update_tick_d = tick;
        moving_up_d   = (state_d == ST_FLYING);
        crashed_d     = (state_d == ST_CRASHED);
    end

    always_ff @(posedge game_tick_clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_READY;
            div_q         <= '0;
            grav_q        <= '0;
            y_q           <= 7'(Y_START);
            vel_q         <= 4'd0;
            tap_pending_q <= 1'b0;
            update_tick_q <= 1'b0;
            moving_up_q   <= 1'b0;
            crashed_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            grav_q        <= grav_d;
            y_q           <= y_d;
            vel_q         <= vel_d;
            tap_pending_q <= tap_pending_d;
            update_tick_q <= update_tick_d;
            moving_up_q   <= moving_up_d;
            crashed_q     <= crashed_d;
        end
    end

    assign y_coordinate = y_q;
    assign velocity     = vel_q;
    assign state        = state_q;
    assign update_tick  = update_tick_q;
    assign moving_up    = moving_up_q;
    assign crashed      = crashed_q;

endmodule

// File: tb/tb_box_motion_controller.sv
// Directed bench for box_motion_controller: full flight/fall/crash trajectory,
// flap coalescing, tap-in-tick, ceiling clamp and asynchronous reset.
module tb_box_motion_controller;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       tap = 1'b0, start = 1'b0;
    logic [6:0] y;
    logic [3:0] vel;
    logic       up, upd, crash;
    logic [1:0] st;

    logic       tap2 = 1'b0, start2 = 1'b0;
    logic [6:0] y2;
    logic [3:0] vel2;
    logic       up2, upd2, crash2;
    logic [1:0] st2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    box_motion_controller #(.TICK_DIV(4), .GRAV_TICKS(2)) dut (
        .game_tick_clock(clk), .resetn(resetn), .tap(tap), .start(start),
        .y_coordinate(y), .velocity(vel), .moving_up(up), .state(st),
        .update_tick(upd), .crashed(crash)
    );

    box_motion_controller #(.TICK_DIV(4), .GRAV_TICKS(2), .Y_START(4)) dut2 (
        .game_tick_clock(clk), .resetn(resetn), .tap(tap2), .start(start2),
        .y_coordinate(y2), .velocity(vel2), .moving_up(up2), .state(st2),
        .update_tick(upd2), .crashed(crash2)
    );

    // Expected trajectory from start, one entry per tick.
    int exp_y [34] = '{54,48,43,38,34,30,27,24,22,20,19,18,
                       18,18,19,20,22,24,27,30,34,38,43,48,54,60,67,74,81,88,95,102,109,112};
    int exp_v [34] = '{6,5,5,4,4,3,3,2,2,1,1,0,
                       0,1,1,2,2,3,3,4,4,5,5,6,6,7,7,7,7,7,7,7,7,0};

    task automatic wait_tick();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (upd) return;
        end
        total++; bad++;
        $display("FAIL tick_timeout: update_tick not seen within 12 cycles");
    endtask

    task automatic wait_tick2();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (upd2) return;
        end
        total++; bad++;
        $display("FAIL tick2_timeout: update_tick not seen within 12 cycles");
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({y, vel, st, upd, up, crash} !== {7'd60, 4'd0, 2'd0, 3'b000}) begin
            bad++;
            $display("FAIL reset_state: y=%0d v=%0d s=%0d upd=%b up=%b cr=%b, want 60 0 0 0 0 0",
                     y, vel, st, upd, up, crash);
        end
        resetn = 1'b1;
    endtask

    task automatic test_ceiling_clamp();
        wait_tick2();
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        total++;
        if ({y2, vel2, st2} !== {7'd4, 4'd6, 2'd2}) begin
            bad++;
            $display("FAIL clamp_start: y=%0d v=%0d s=%0d, want 4 6 2", y2, vel2, st2);
        end
        wait_tick2();
        total++;
        if ({y2, vel2, st2, crash2, up2} !== {7'd0, 4'd0, 2'd1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL clamp_tick: y=%0d v=%0d s=%0d cr=%b up=%b, want 0 0 1 0 0",
                     y2, vel2, st2, crash2, up2);
        end
    endtask

    task automatic test_flight_and_crash();
        wait_tick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if ({y, vel, st, up} !== {7'd60, 4'd6, 2'd2, 1'b1}) begin
            bad++;
            $display("FAIL start: y=%0d v=%0d s=%0d up=%b, want 60 6 2 1", y, vel, st, up);
        end
        for (int t = 0; t < 34; t++) begin
            logic [1:0] es;
            es = (t < 11) ? 2'd2 : ((t < 33) ? 2'd1 : 2'd3);
            wait_tick();
            total++;
            if (y !== 7'(exp_y[t]) || vel !== 4'(exp_v[t]) || st !== es ||
                up !== (es == 2'd2) || crash !== (es == 2'd3)) begin
                bad++;
                $display("FAIL trajectory_tick%0d: y=%0d v=%0d s=%0d up=%b cr=%b, want %0d %0d %0d",
                         t + 1, y, vel, st, up, crash, exp_y[t], exp_v[t], es);
            end
        end
    endtask

    task automatic test_crashed_restart();
        tap = 1'b1;
        @(negedge clk);
        tap = 1'b0;
        wait_tick();
        total++;
        if ({y, vel, st, crash} !== {7'd112, 4'd0, 2'd3, 1'b1}) begin
            bad++;
            $display("FAIL crashed_frozen: y=%0d v=%0d s=%0d cr=%b, want 112 0 3 1", y, vel, st, crash);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if ({y, vel, st, crash} !== {7'd60, 4'd0, 2'd0, 1'b0}) begin
            bad++;
            $display("FAIL restart_ready: y=%0d v=%0d s=%0d cr=%b, want 60 0 0 0", y, vel, st, crash);
        end
    endtask

    task automatic test_double_tap();
        wait_tick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 12; t++) wait_tick();
        total++;
        if ({y, vel, st} !== {7'd18, 4'd0, 2'd1}) begin
            bad++;
            $display("FAIL pre_double_tap: y=%0d v=%0d s=%0d, want 18 0 1", y, vel, st);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tap = 1'b1;
        total++;
        if (st !== 2'd1) begin
            bad++;
            $display("FAIL start_ignored_falling: s=%0d, want 1", st);
        end
        @(negedge clk);
        tap = 1'b0;
        @(negedge clk);
        tap = 1'b1;
        wait_tick();
        tap = 1'b0;
        total++;
        if ({y, vel, st, up} !== {7'd18, 4'd6, 2'd2, 1'b1}) begin
            bad++;
            $display("FAIL double_tap_flap: y=%0d v=%0d s=%0d up=%b, want 18 6 2 1", y, vel, st, up);
        end
        wait_tick();
        total++;
        if ({y, vel, st} !== {7'd12, 4'd6, 2'd2}) begin
            bad++;
            $display("FAIL after_flap_1: y=%0d v=%0d s=%0d, want 12 6 2", y, vel, st);
        end
        wait_tick();
        total++;
        if ({y, vel, st} !== {7'd6, 4'd5, 2'd2}) begin
            bad++;
            $display("FAIL after_flap_2: y=%0d v=%0d s=%0d, want 6 5 2", y, vel, st);
        end
    endtask

    task automatic test_tap_in_tick();
        repeat (3) @(negedge clk);
        tap = 1'b1;
        wait_tick();
        tap = 1'b0;
        total++;
        if ({y, vel, st} !== {7'd6, 4'd6, 2'd2}) begin
            bad++;
            $display("FAIL tap_in_tick: y=%0d v=%0d s=%0d, want 6 6 2", y, vel, st);
        end
        wait_tick();
        total++;
        if ({y, vel, st, crash} !== {7'd0, 4'd0, 2'd1, 1'b0}) begin
            bad++;
            $display("FAIL ceiling_exact: y=%0d v=%0d s=%0d cr=%b, want 0 0 1 0", y, vel, st, crash);
        end
    endtask

    task automatic test_async_reset();
        int n;
        tap = 1'b1;
        @(negedge clk);
        tap = 1'b0;
        wait_tick();
        total++;
        if ({y, vel, st} !== {7'd0, 4'd6, 2'd2}) begin
            bad++;
            $display("FAIL flap_from_ceiling: y=%0d v=%0d s=%0d, want 0 6 2", y, vel, st);
        end
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        total++;
        if ({y, vel, st, upd, up} !== {7'd60, 4'd0, 2'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL async_reset: y=%0d v=%0d s=%0d upd=%b up=%b, want 60 0 0 0 0",
                     y, vel, st, upd, up);
        end
        @(negedge clk);
        resetn = 1'b1;
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (upd) begin
                n = i;
                break;
            end
        end
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL divider_restart: first tick after %0d cycles, want 4", n);
        end
    endtask

    initial begin
        test_reset();
        test_ceiling_clamp();
        test_flight_and_crash();
        test_crashed_restart();
        test_double_tap();
        test_tap_in_tick();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
